// File: rtl/inst_aligner.sv
// inst_aligner: buffers I-cache halfwords in a 4-entry queue and emits one
// 16/32-bit instruction per cycle, handling straddles, rollback and redirects.
module inst_aligner #(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              rollback,
  input  logic [ADDR_W-1:0] rollback_pc,
  output logic              ic_req_valid,
  output logic [ADDR_W-1:0] ic_req_addr,
  input  logic              ic_req_ready,
  input  logic              ic_rsp_valid,
  input  logic [31:0]       ic_rsp_data,
  output logic [ADDR_W-1:0] pred_pc,
  output logic [31:0]       pred_inst,
  input  logic              pred_taken,
  input  logic [ADDR_W-1:0] pred_target,
  input  logic              out_ready,
  output logic              out_inst_valid,
  output logic [31:0]       out_inst,
  output logic              out_inst_predict_jump,
  output logic [ADDR_W-1:0] out_inst_pc
);
  logic [3:0][15:0]  hw_q, hw_d;
  logic [1:0]        head_q, head_d, tail;
  logic [2:0]        count_q, count_d, push_n, pop_n;
  logic [ADDR_W-1:0] head_pc_q, head_pc_d, fetch_pc_q, fetch_pc_d, tgt;
  logic              outstanding_q, outstanding_d, stale_q, stale_d, drop_low_q, drop_low_d;
  logic [15:0]       h0, h1;
  logic              is32, avail, fire, taken, redirect, rsp;
  always_comb begin
    h0 = hw_q[head_q];
    h1 = hw_q[head_q + 2'd1];
    is32 = h0[1:0] == 2'b11;
    avail = is32 ? count_q >= 3'd2 : count_q >= 3'd1;
    out_inst_valid = avail & rdy & !rollback;
    out_inst = is32 ? {h1, h0} : {16'b0, h0};
    out_inst_pc = head_pc_q;
    out_inst_predict_jump = pred_taken;
    pred_pc = head_pc_q;
    pred_inst = out_inst;
    fire = out_inst_valid & out_ready;
    taken = fire & pred_taken;
    redirect = rdy & (rollback | taken);
    tgt = rollback ? rollback_pc : pred_target;
    ic_req_valid = rst & rdy & !rollback & !outstanding_q & (count_q <= 3'd2) & !taken;
    ic_req_addr = fetch_pc_q;
    rsp = ic_rsp_valid & outstanding_q;
    tail = head_q + count_q[1:0];
    pop_n = (fire & !pred_taken) ? (is32 ? 3'd2 : 3'd1) : 3'd0;
    push_n = (rsp & !stale_q) ? (drop_low_q ? 3'd1 : 3'd2) : 3'd0;
    hw_d = hw_q;
    head_d = head_q;
    count_d = count_q;
    head_pc_d = head_pc_q;
    fetch_pc_d = fetch_pc_q;
    outstanding_d = outstanding_q;
    stale_d = stale_q;
    drop_low_d = drop_low_q;
    if (redirect) begin
      count_d = 3'd0;
      head_pc_d = tgt & ~ADDR_W'(1);
      fetch_pc_d = tgt & ~ADDR_W'(3);
      drop_low_d = tgt[1];
      // an in-flight read that has not returned yet belongs to the old stream
      outstanding_d = outstanding_q & !ic_rsp_valid;
      stale_d = outstanding_q & !ic_rsp_valid;
    end else if (rdy) begin
      head_d = head_q + pop_n[1:0];
      head_pc_d = head_pc_q + ADDR_W'({pop_n, 1'b0});
      count_d = count_q + push_n - pop_n;
      if (ic_req_valid & ic_req_ready) begin
        outstanding_d = 1'b1;
        fetch_pc_d = fetch_pc_q + ADDR_W'(4);
      end
      if (rsp) begin
        outstanding_d = 1'b0;
        stale_d = 1'b0;
        if (!stale_q & drop_low_q) begin
          hw_d[tail] = ic_rsp_data[31:16];
          drop_low_d = 1'b0;
        end else if (!stale_q) begin
          hw_d[tail] = ic_rsp_data[15:0];
          hw_d[tail + 2'd1] = ic_rsp_data[31:16];
        end
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hw_q <= '0;
      head_q <= '0;
      count_q <= '0;
      head_pc_q <= RESET_PC;
      fetch_pc_q <= RESET_PC & ~ADDR_W'(3);
      outstanding_q <= 1'b0;
      stale_q <= 1'b0;
      drop_low_q <= RESET_PC[1];
    end else begin
      hw_q <= hw_d;
      head_q <= head_d;
      count_q <= count_d;
      head_pc_q <= head_pc_d;
      fetch_pc_q <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      stale_q <= stale_d;
      drop_low_q <= drop_low_d;
    end
  end
endmodule

// File: doc/inst_aligner.md
Name: inst_aligner

Overview:
- Fetch-side halfword aligner placed directly upstream of the compressed-instruction expander.
- Issues word-aligned I-cache reads and buffers returned halfwords in a 4-entry queue.
- Extracts one 16-bit or 32-bit instruction per cycle, including 32-bit instructions that straddle a word boundary, and presents it with PC and jump-prediction flag.
- Handles backend rollback and predictor redirects, flushing the queue and discarding stale responses.

Parameters:
- RESET_PC, 32'h0, PC loaded on reset.
- ADDR_W, 32, address width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- rdy  in  1  global enable; when 0 all state is frozen.
- rollback  in  1  backend flush.
- rollback_pc  in  32  restart PC; bit0 ignored.
- ic_req_valid  out  1  read request.
- ic_req_addr  out  32  word-aligned read address.
- ic_req_ready  in  1  request accepted this cycle.
- ic_rsp_valid  in  1  read data returned.
- ic_rsp_data  in  32  returned word; bits [15:0] are the lower halfword.
- pred_pc  out  32  head instruction PC, driven to the predictor.
- pred_inst  out  32  head instruction, driven to the predictor.
- pred_taken  in  1  combinational predictor result for the head instruction.
- pred_target  in  32  predicted target.
- out_ready  in  1  downstream can accept.
- out_inst_valid  out  1  instruction valid.
- out_inst  out  32  instruction; compressed form is {16'b0, hw}.
- out_inst_predict_jump  out  1  predictor said taken.
- out_inst_pc  out  32  instruction PC.

Behaviour:
- State:
  - hw queue of 4 x 16 bits; head ptr [1:0]; count 0..4.
  - head_pc; fetch_pc (word-aligned).
  - outstanding (0/1); stale (0/1); drop_low (0/1).
- Reset (rst=0, asynchronous):
  - count=0, outstanding=0, stale=0.
  - head_pc=RESET_PC; fetch_pc={RESET_PC[31:2],2'b00}; drop_low=RESET_PC[1].
  - Outputs ic_req_valid=0 and out_inst_valid=0 while reset is asserted.
- Availability:
  - head hw[1:0]!=2'b11 needs count>=1 (16-bit).
  - Otherwise needs count>=2 (32-bit, inst={hw[head+1], hw[head]}).
- Outputs are combinational from queue state:
  - out_inst_valid = avail & rdy & !rollback.
  - out_inst_pc = head_pc.
  - pred_pc and pred_inst track the head instruction.
  - out_inst_predict_jump = pred_taken.
- Consume when out_inst_valid & out_ready:
  - Pop 1 or 2 halfwords; head_pc += 2 or 4.
  - If pred_taken, instead treat as a redirect to pred_target.
- Request:
  - ic_req_valid = rdy & !rollback & !outstanding & (count<=2) & !redirect_this_cycle.
  - ic_req_addr = fetch_pc.
  - On ic_req_valid & ic_req_ready: outstanding=1, fetch_pc += 4.
  - At most one request outstanding.
- Response (ic_rsp_valid, outstanding=1):
  - outstanding=0.
  - If stale: drop data, stale=0.
  - Else if drop_low: push only [31:16] and clear drop_low.
  - Else push both halfwords, low halfword first.
- Push and pop in the same cycle are legal: count_next = count + pushed − popped, never >4. The request rule guarantees space.
- Redirect (rollback has priority over pred_taken):
  - Flush: count=0.
  - head_pc = target with bit0 cleared; fetch_pc = {target[31:2],2'b00}; drop_low = target[1].
  - No request is issued in the redirect cycle.
  - If outstanding and no response this cycle: stale=1. A response arriving in the redirect cycle is discarded.
  - On rollback, out_inst_valid=0 that cycle.
- rdy=0: no state update, no request, out_inst_valid=0.
- Wrap-around: head ptr and tail are mod 4. PCs wrap mod 2^32.
- Reset asserted mid-request: outstanding is cleared. The I-cache must drop an in-flight response on reset.

Test Plan:
- Word-aligned mixed stream: reset, RESET_PC=0, mem[0]=0x00A00513, mem[4]=0x45854505 -> outputs (pc 0, 0x00A00513), (pc 4, 0x00004505), (pc 6, 0x00004585) in order; requests at 0x0 and 0x4.
- Straddling 32-bit instruction: mem[0]=0x05134505, mem[4]=0x458500A0 -> (pc 0, 0x00004505), (pc 2, 0x00A00513) emitted only after word 4 returns, then (pc 6, 0x00004585).
- Rollback with stale response: request to 0x8 accepted; rollback, rollback_pc=0x102 before response -> the 0x8 response is dropped, next ic_req_addr=0x100, low halfword discarded, first output pc=0x102.
- Backpressure: out_ready=0 until count=4 -> ic_req_valid stays 0; out_inst and out_inst_pc held stable; releasing out_ready resumes requests.
- Predictor redirect: head at pc 4 with pred_taken=1, pred_target=0x200 -> out_inst_predict_jump=1 on that output; queue flushed; next ic_req_addr=0x200; next output pc=0x200.
- Freeze and reset: rdy=0 with a response pending -> nothing consumed or issued. Asserting rst low mid-request -> count=0, ic_req_valid=0 immediately; after release, first request is at RESET_PC.
